// File: rtl/updown_seq_pkg.sv
// Shared definitions for the up/down count sequencer.
//   state_t    : sequencer FSM states
//   max_count(): largest value of a width-bit unsigned counter
//   DEF_*      : default counter and step-field widths
package updown_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_STEP_W = 4;

    function automatic int max_count(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/updown_count_core.sv
// Registered WIDTH-bit up/down counter with wrap/saturate at the limits.
//   clk, rst  : clock, async active-high reset
//   en        : take one step this edge
//   up        : step direction (1 = up)
//   load      : load load_val this edge (wins over en)
//   load_val  : value to load
//   wrap      : 1 = wrap at limits, 0 = saturate
//   count     : counter value
//   wrap_evt  : pulse in the cycle the counter shows the wrapped value
//   sat_hit   : pulse in the cycle after a step was absorbed at a limit
module updown_count_core
    import updown_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             wrap,
    output logic [WIDTH-1:0] count,
    output logic             wrap_evt,
    output logic             sat_hit
);

    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(max_count(WIDTH));

    logic at_limit;
    assign at_limit = up ? (count == MAX_COUNT) : (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            wrap_evt <= 1'b0;
            sat_hit  <= 1'b0;
        end else begin
            // Event flags are single-cycle: cleared unless this edge sets them.
            wrap_evt <= 1'b0;
            sat_hit  <= 1'b0;
            if (load) begin
                count <= load_val;
            end else if (en) begin
                if (at_limit) begin
                    if (wrap) begin
                        count    <= up ? '0 : MAX_COUNT;
                        wrap_evt <= 1'b1;
                    end else begin
                        sat_hit  <= 1'b1;   // count holds, step still consumed
                    end
                end else begin
                    count <= up ? count + WIDTH'(1) : count - WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: rtl/updown_count_sequencer.sv
// Command-driven sequencer for an up/down counter. A host issues load or
// step-N commands over valid/ready; steps are applied one per clock while
// in RUN (held by pause), and a one-cycle done pulse marks completion.
//   clk, rst      : clock, async active-high reset
//   cmd_valid/ready: command handshake (ready only in IDLE, low in reset)
//   cmd_load      : 1 = load cmd_load_val, 0 = step cmd_steps times
//   cmd_up        : step direction, latched per command
//   cmd_steps     : step count (0 completes immediately)
//   cmd_load_val  : load value
//   mode_wrap     : wrap (1) or saturate (0), sampled live on each step
//   pause         : hold stepping in RUN
//   count         : counter value
//   busy          : high in RUN
//   done          : one-cycle completion pulse
//   wrap_evt      : counter wrapped (aligned with the wrapped value)
//   sat_hit       : step absorbed at a limit
module updown_count_sequencer
    import updown_seq_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STEP_W = DEF_STEP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_load,
    input  logic              cmd_up,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic [WIDTH-1:0]  cmd_load_val,
    input  logic              mode_wrap,
    input  logic              pause,
    output logic [WIDTH-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic              wrap_evt,
    output logic              sat_hit
);

    state_t            state, state_nxt;
    logic [STEP_W-1:0] remaining;
    logic              dir;
    logic              accept;
    logic              step_en;
    logic              idle_st;

    assign accept  = cmd_valid && cmd_ready;
    assign step_en = (state == RUN) && !pause;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) begin
                if (cmd_load || cmd_steps == '0) state_nxt = DONE;
                else                             state_nxt = RUN;
            end
            RUN:  if (step_en && remaining == STEP_W'(1)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        idle_st = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE:    idle_st = 1'b1;
            RUN:     busy    = 1'b1;
            DONE:    done    = 1'b1;
            default: ;
        endcase
    end

    // Ready is gated by rst directly so it drops the moment reset asserts.
    assign cmd_ready = idle_st && !rst;

    // Step bookkeeping: remaining counts down one per executed step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= '0;
            dir       <= 1'b0;
        end else if (accept && !cmd_load) begin
            remaining <= cmd_steps;
            dir       <= cmd_up;
        end else if (step_en) begin
            remaining <= remaining - STEP_W'(1);
        end
    end

    updown_count_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst      (rst),
        .en       (step_en),
        .up       (dir),
        .load     (accept && cmd_load),
        .load_val (cmd_load_val),
        .wrap     (mode_wrap),
        .count    (count),
        .wrap_evt (wrap_evt),
        .sat_hit  (sat_hit)
    );

endmodule
